// File: rtl/rv_decode_pkg.sv
// Shared RV32I decode definitions: opcodes, the canonical NOP and immediate formats.
package rv_decode_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_NONE, FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J
    } imm_fmt_e;

    function automatic imm_fmt_e fmt_of(input logic [6:0] opc);
        case (opc)
            OPC_LUI, OPC_AUIPC:             return FMT_U;
            OPC_JAL:                        return FMT_J;
            OPC_JALR, OPC_LOAD, OPC_OPIMM:  return FMT_I;
            OPC_BRANCH:                     return FMT_B;
            OPC_STORE:                      return FMT_S;
            OPC_OP:                         return FMT_R;
            default:                        return FMT_NONE;
        endcase
    endfunction

    function automatic logic signed [31:0] imm_of(input logic [31:0] inst, input imm_fmt_e fmt);
        case (fmt)
            FMT_I:   return {{20{inst[31]}}, inst[31:20]};
            FMT_S:   return {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   return {inst[31:12], 12'b0};
            FMT_J:   return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/rv_regfile.sv
// Two-read, one-write register file with x0 hard-wired to zero and write-to-read bypass.
module rv_regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [4:0]      wa,
    input  logic [XLEN-1:0] wd
);
    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0] regs [NREG];

    // Indices beyond NREG are never written and always read as zero.
    function automatic logic [XLEN-1:0] read_port(input logic [4:0] a);
        if (a == 5'd0 || 32'(a) >= NREG) return '0;
        if (we && wa == a)               return wd;
        return regs[a[AW-1:0]];
    endfunction

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (we && wa != 5'd0 && 32'(wa) < NREG) begin
            regs[wa[AW-1:0]] <= wd;
        end
    end

    always_comb begin
        rd1 = read_port(rs1);
        rd2 = read_port(rs2);
    end

endmodule

// File: rtl/decode_issue_unit.sv
// RV32I decode/issue stage: decodes one instruction per cycle into an execute bundle
// and stalls consumers of in-flight load results.
module decode_issue_unit
    import rv_decode_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int LOAD_LAT = 1
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_value,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_store_value,
    output logic [XLEN-1:0] out_pc,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [2:0]      out_mem_para,
    output logic            out_wb,
    output logic            out_mem,
    output logic            out_load,
    output logic            out_branch,
    output logic            out_jump,
    output logic            out_imm_flag,
    output logic            out_illegal
);
    typedef struct packed {
        logic [4:0]      rd, rs1, rs2;
        logic [XLEN-1:0] op1, op2, imm, store_value, pc;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [2:0]      mem_para;
        logic            wb, mem, load, branch, jump, imm_flag, illegal;
    } bundle_t;

    logic [6:0]             opc_p0, f7_p0;
    logic [2:0]             f3_p0;
    logic [4:0]             rd_p0, rs1_p0, rs2_p0;
    logic [XLEN-1:0]        rs1_val_p0, rs2_val_p0;
    imm_fmt_e               fmt_p0;
    logic signed [XLEN-1:0] imm_p0;
    logic                   use_rd, use_rs1, use_rs2, legal_opc, bad_reg, illegal_p0;
    logic                   hazard, accept, vld_p1;
    bundle_t                bundle_p0, bundle_p1;
    logic [4:0]             track_p1 [LOAD_LAT];

    assign opc_p0 = in_inst[6:0];
    assign rd_p0  = in_inst[11:7];
    assign f3_p0  = in_inst[14:12];
    assign rs1_p0 = in_inst[19:15];
    assign rs2_p0 = in_inst[24:20];
    assign f7_p0  = in_inst[31:25];
    assign fmt_p0 = fmt_of(opc_p0);
    assign imm_p0 = XLEN'(imm_of(in_inst, fmt_p0));

    rv_regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
        .CLK(CLK), .reset(reset),
        .rs1(rs1_p0), .rs2(rs2_p0), .rd1(rs1_val_p0), .rd2(rs2_val_p0),
        .we(wb_en), .wa(wb_rd), .wd(wb_value)
    );

    assign bad_reg = (use_rd  && 32'(rd_p0)  >= NREG) ||
                     (use_rs1 && 32'(rs1_p0) >= NREG) ||
                     (use_rs2 && 32'(rs2_p0) >= NREG);
    assign illegal_p0 = !legal_opc || bad_reg;

    always_comb begin
        bundle_p0 = '0;
        use_rd    = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        legal_opc = 1'b1;
        bundle_p0.imm      = imm_p0;
        bundle_p0.pc       = in_pc;
        bundle_p0.imm_flag = (fmt_p0 != FMT_NONE) && (fmt_p0 != FMT_R);
        case (opc_p0)
            OPC_LUI:    begin use_rd = 1'b1; bundle_p0.op1 = imm_p0; end
            OPC_AUIPC:  begin use_rd = 1'b1; bundle_p0.op1 = imm_p0; bundle_p0.op2 = in_pc; end
            OPC_JAL:    begin
                use_rd = 1'b1; bundle_p0.jump = 1'b1;
                bundle_p0.op1 = in_pc; bundle_p0.op2 = XLEN'(4);
            end
            OPC_JALR:   begin
                use_rd = 1'b1; use_rs1 = 1'b1; bundle_p0.jump = 1'b1;
                bundle_p0.op1 = in_pc; bundle_p0.op2 = XLEN'(4);
            end
            OPC_BRANCH: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; bundle_p0.branch = 1'b1;
                bundle_p0.op1 = rs1_val_p0; bundle_p0.op2 = rs2_val_p0; bundle_p0.funct3 = f3_p0;
            end
            OPC_LOAD:   begin
                use_rd = 1'b1; use_rs1 = 1'b1; bundle_p0.mem = 1'b1; bundle_p0.load = 1'b1;
                bundle_p0.op1 = rs1_val_p0; bundle_p0.op2 = imm_p0; bundle_p0.mem_para = f3_p0;
            end
            OPC_STORE:  begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; bundle_p0.mem = 1'b1;
                bundle_p0.op1 = rs1_val_p0; bundle_p0.op2 = imm_p0; bundle_p0.mem_para = f3_p0;
                bundle_p0.store_value = rs2_val_p0;
            end
            OPC_OPIMM:  begin
                use_rd = 1'b1; use_rs1 = 1'b1;
                bundle_p0.op1 = rs1_val_p0; bundle_p0.op2 = imm_p0; bundle_p0.funct3 = f3_p0;
                // Only shifts carry a meaningful funct7 (SRAI vs SRLI).
                bundle_p0.funct7 = (f3_p0 == 3'b001 || f3_p0 == 3'b101) ? f7_p0 : 7'd0;
            end
            OPC_OP:     begin
                use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                bundle_p0.op1 = rs1_val_p0; bundle_p0.op2 = rs2_val_p0;
                bundle_p0.funct3 = f3_p0; bundle_p0.funct7 = f7_p0;
            end
            default:    legal_opc = 1'b0;
        endcase
        bundle_p0.rd  = use_rd  ? rd_p0  : 5'd0;
        bundle_p0.rs1 = use_rs1 ? rs1_p0 : 5'd0;
        bundle_p0.rs2 = use_rs2 ? rs2_p0 : 5'd0;
        bundle_p0.wb  = use_rd && !illegal_p0;
        bundle_p0.illegal = illegal_p0;
        if (illegal_p0) begin
            bundle_p0.mem    = 1'b0;
            bundle_p0.load   = 1'b0;
            bundle_p0.branch = 1'b0;
            bundle_p0.jump   = 1'b0;
        end
    end

    // Tracker entries are nonzero only for live loads, so x0 never matches.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < LOAD_LAT; i++) begin
            if (track_p1[i] != 5'd0 &&
                ((use_rs1 && rs1_p0 == track_p1[i]) || (use_rs2 && rs2_p0 == track_p1[i])))
                hazard = 1'b1;
        end
    end

    assign in_ready = (!vld_p1 || out_ready) && !hazard && !flush;
    assign accept   = in_valid && in_ready;

    // ---- p0 -> p1: issue register ----
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            vld_p1    <= 1'b0;
            bundle_p1 <= '0;
        end else if (flush) begin
            vld_p1    <= 1'b0;
        end else if (accept) begin
            vld_p1    <= 1'b1;
            bundle_p1 <= bundle_p0;
        end else if (out_ready) begin
            vld_p1    <= 1'b0;
        end
    end

    // Head is always empty when nothing is issued, so a non-advancing accept may write it.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset || flush) begin
            for (int i = 0; i < LOAD_LAT; i++) track_p1[i] <= 5'd0;
        end else if (out_ready) begin
            track_p1[0] <= (accept && bundle_p0.load) ? bundle_p0.rd : 5'd0;
            for (int i = 1; i < LOAD_LAT; i++) track_p1[i] <= track_p1[i-1];
        end else if (accept && bundle_p0.load) begin
            track_p1[0] <= bundle_p0.rd;
        end
    end

    assign out_valid       = vld_p1;
    assign out_rd          = bundle_p1.rd;
    assign out_rs1         = bundle_p1.rs1;
    assign out_rs2         = bundle_p1.rs2;
    assign out_op1         = bundle_p1.op1;
    assign out_op2         = bundle_p1.op2;
    assign out_imm         = bundle_p1.imm;
    assign out_store_value = bundle_p1.store_value;
    assign out_pc          = bundle_p1.pc;
    assign out_funct3      = bundle_p1.funct3;
    assign out_funct7      = bundle_p1.funct7;
    assign out_mem_para    = bundle_p1.mem_para;
    assign out_wb          = bundle_p1.wb;
    assign out_mem         = bundle_p1.mem;
    assign out_load        = bundle_p1.load;
    assign out_branch      = bundle_p1.branch;
    assign out_jump        = bundle_p1.jump;
    assign out_imm_flag    = bundle_p1.imm_flag;
    assign out_illegal     = bundle_p1.illegal;

endmodule

// File: tb/tb_decode_issue_unit.sv
// Scoreboard bench for decode_issue_unit: a default instance plus an RV32E (NREG=16) twin.
module tb_decode_issue_unit;

    logic        CLK = 1'b0;
    logic        reset, in_valid, wb_en, flush, out_ready;
    logic [31:0] in_inst, in_pc, wb_value;
    logic [4:0]  wb_rd;

    logic        in_ready, out_valid, out_wb, out_mem, out_load, out_branch, out_jump, out_imm_flag, out_illegal;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [31:0] out_op1, out_op2, out_imm, out_store_value, out_pc;
    logic [2:0]  out_funct3, out_mem_para;
    logic [6:0]  out_funct7;

    logic        d_in_ready, d_out_valid, d_wb, d_mem, d_load, d_branch, d_jump, d_imm_flag, d_illegal;
    logic [4:0]  d_rd, d_rs1, d_rs2;
    logic [31:0] d_op1, d_op2, d_imm, d_sv, d_pc;
    logic [2:0]  d_funct3, d_mem_para;
    logic [6:0]  d_funct7;

    always #5 CLK = ~CLK;

    decode_issue_unit #(.XLEN(32), .NREG(32), .LOAD_LAT(1)) dut (
        .CLK(CLK), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_value(wb_value), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_op1(out_op1), .out_op2(out_op2), .out_imm(out_imm), .out_store_value(out_store_value), .out_pc(out_pc),
        .out_funct3(out_funct3), .out_funct7(out_funct7), .out_mem_para(out_mem_para),
        .out_wb(out_wb), .out_mem(out_mem), .out_load(out_load), .out_branch(out_branch), .out_jump(out_jump),
        .out_imm_flag(out_imm_flag), .out_illegal(out_illegal)
    );

    decode_issue_unit #(.XLEN(32), .NREG(16), .LOAD_LAT(1)) dut16 (
        .CLK(CLK), .reset(reset), .in_valid(in_valid), .in_ready(d_in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_value(wb_value), .flush(flush),
        .out_valid(d_out_valid), .out_ready(out_ready), .out_rd(d_rd), .out_rs1(d_rs1), .out_rs2(d_rs2),
        .out_op1(d_op1), .out_op2(d_op2), .out_imm(d_imm), .out_store_value(d_sv), .out_pc(d_pc),
        .out_funct3(d_funct3), .out_funct7(d_funct7), .out_mem_para(d_mem_para),
        .out_wb(d_wb), .out_mem(d_mem), .out_load(d_load), .out_branch(d_branch), .out_jump(d_jump),
        .out_imm_flag(d_imm_flag), .out_illegal(d_illegal)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] op1, op2, imm, sv;
        logic        wb, ill, ill16;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, want, $time);
        end
    endtask

    function automatic exp_t mk(input logic [4:0] rd, input logic [31:0] op1, op2, imm, sv,
                                input logic wb, ill, ill16);
        exp_t e;
        e.rd = rd; e.op1 = op1; e.op2 = op2; e.imm = imm; e.sv = sv;
        e.wb = wb; e.ill = ill; e.ill16 = ill16;
        return e;
    endfunction

    always @(negedge CLK) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_bundle", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rd", out_rd, mon_e.rd);
                chk("op1", out_op1, mon_e.op1);
                chk("op2", out_op2, mon_e.op2);
                chk("imm", out_imm, mon_e.imm);
                chk("store_value", out_store_value, mon_e.sv);
                chk("wb", out_wb, mon_e.wb);
                chk("illegal", out_illegal, mon_e.ill);
                chk("rv32e_valid", d_out_valid, 1);
                chk("rv32e_illegal", d_illegal, mon_e.ill16);
            end
        end
    end

    task automatic wb_write(input logic [4:0] rd, input logic [31:0] val);
        wb_en = 1'b1; wb_rd = rd; wb_value = val;
        @(posedge CLK); #1;
        wb_en = 1'b0;
    endtask

    task automatic issue(input logic [31:0] inst, input logic [31:0] pc, input exp_t e,
                         input bit push, output int waits);
        bit ok = 1'b0;
        waits = 0;
        in_valid = 1'b1; in_inst = inst; in_pc = pc;
        for (int n = 0; n < 20; n++) begin
            @(negedge CLK);
            if (in_ready) begin ok = 1'b1; break; end
            waits++;
            @(posedge CLK); #1;
        end
        if (!ok) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        if (push) exp_q.push_back(e);
        @(posedge CLK); #1;
        in_valid = 1'b0;
        chk("latency_valid", out_valid, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        reset = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0;
        wb_en = 1'b0; wb_rd = '0; wb_value = '0; flush = 1'b0; out_ready = 1'b1;

        @(negedge CLK);
        chk("reset_valid", out_valid, 0);
        chk("reset_wb", out_wb, 0);
        chk("reset_op1", out_op1, 0);
        chk("reset_rd", out_rd, 0);
        @(posedge CLK); #1;
        reset = 1'b1;

        wb_write(5'd1, 32'h100);
        wb_write(5'd2, 32'h20);

        // ADDI x5,x0,7
        issue(32'h00700293, 32'h0, mk(5, 0, 7, 7, 0, 1, 0, 0), 1, w);

        // LW x6,0(x1) then dependent ADD x7,x6,x2: exactly one stall cycle
        issue(32'h0000A303, 32'h4, mk(6, 32'h100, 0, 0, 0, 1, 0, 0), 1, w);
        issue(32'h002303B3, 32'h8, mk(7, 0, 32'h20, 0, 0, 1, 0, 0), 1, w);
        chk("load_use_stall_cycles", w, 1);

        // ORI x9,x1,0xF0 held for three cycles of backpressure
        issue(32'h0F00E493, 32'hC, mk(9, 32'h100, 32'hF0, 32'hF0, 0, 1, 0, 0), 1, w);
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h12345537;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("hold_valid", out_valid, 1);
            chk("hold_rd", out_rd, 9);
            chk("hold_op2", out_op2, 32'hF0);
            chk("hold_in_ready", in_ready, 0);
            @(posedge CLK); #1;
        end
        out_ready = 1'b1;
        // LUI x10,0x12345
        issue(32'h12345537, 32'h10, mk(10, 32'h12345000, 0, 32'h12345000, 0, 1, 0, 0), 1, w);
        chk("after_hold_wait", w, 0);

        // ADD x4,x3,x0 with same-cycle write-back of x3
        wb_en = 1'b1; wb_rd = 5'd3; wb_value = 32'h1234;
        issue(32'h00018233, 32'h14, mk(4, 32'h1234, 0, 0, 0, 1, 0, 0), 1, w);
        wb_en = 1'b0;

        // JAL x1,+8 ; SW x2,-4(x1) ; BNE x1,x2,+16
        issue(32'h008000EF, 32'h200, mk(1, 32'h200, 4, 8, 0, 1, 0, 0), 1, w);
        issue(32'hFE20AE23, 32'h204, mk(0, 32'h100, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h20, 0, 0, 0), 1, w);
        issue(32'h00209863, 32'h208, mk(0, 32'h100, 32'h20, 16, 0, 0, 0, 0), 1, w);
        @(negedge CLK); @(posedge CLK); #1;

        // Flush with a load pending: bundle dropped and tracker cleared
        out_ready = 1'b0;
        issue(32'h0000A303, 32'h300, mk(6, 0, 0, 0, 0, 0, 0, 0), 0, w);
        flush = 1'b1;
        in_valid = 1'b1; in_inst = 32'h002303B3;
        @(negedge CLK);
        chk("flush_in_ready", in_ready, 0);
        @(posedge CLK); #1;
        flush = 1'b0;
        out_ready = 1'b1;
        chk("flush_valid", out_valid, 0);
        issue(32'h002303B3, 32'h400, mk(7, 0, 32'h20, 0, 0, 1, 0, 0), 1, w);
        chk("flush_no_stall", w, 0);

        // Illegal opcode, then x17 (legal on RV32I, illegal on RV32E)
        issue(32'h0000007F, 32'h404, mk(0, 0, 0, 0, 0, 0, 1, 1), 1, w);
        issue(32'h002088B3, 32'h408, mk(17, 32'h100, 32'h20, 0, 0, 1, 0, 1), 1, w);
        @(negedge CLK); @(posedge CLK); #1;

        // Mid-operation reset discards the bundle and clears the register file
        out_ready = 1'b0;
        issue(32'h00700293, 32'h500, mk(5, 0, 7, 7, 0, 1, 0, 0), 0, w);
        #2 reset = 1'b0;
        #1;
        chk("midreset_valid", out_valid, 0);
        chk("midreset_op2", out_op2, 0);
        @(posedge CLK); #1;
        reset = 1'b1;
        out_ready = 1'b1;
        issue(32'h00008233, 32'h0, mk(4, 0, 0, 0, 0, 1, 0, 0), 1, w);

        repeat (3) @(posedge CLK);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_issue_unit.md
DECODE_ISSUE_UNIT -- requirements
Module: decode_issue_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the datapath width of operands, PC and register contents.
REQ-002 The block SHALL have parameter NREG, default 32, meaning the architectural register count (16 selects RV32E; register indices at or above NREG are illegal).
REQ-003 The block SHALL have parameter LOAD_LAT, default 1, range 1..4, meaning the number of downstream advances before a load result can be forwarded.
REQ-004 The block SHALL have port CLK  in  1  rising-edge clock.
REQ-005 The block SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port in_valid  in  1  fetch presents an instruction.
REQ-007 The block SHALL have port in_ready  out  1  decode accepts the instruction this cycle.
REQ-008 The block SHALL have port in_inst  in  32  instruction word.
REQ-009 The block SHALL have port in_pc  in  XLEN  instruction PC.
REQ-010 The block SHALL have ports wb_en, wb_rd and wb_value  in  1/5/XLEN  register write-back.
REQ-011 The block SHALL have port flush  in  1  discards the issued and tracked state (branch or jump redirect).
REQ-012 The block SHALL have port out_valid  out  1  execute bundle valid.
REQ-013 The block SHALL have port out_ready  in  1  execute accepts the bundle; the downstream pipeline advances.
REQ-014 The block SHALL have ports out_rd, out_rs1 and out_rs2  out  5  register indices (forced to 0 when unused).
REQ-015 The block SHALL have ports out_op1, out_op2, out_imm, out_store_value and out_pc  out  XLEN  operands, immediate, store data and PC.
REQ-016 The block SHALL have ports out_funct3, out_funct7 and out_mem_para  out  3/7/3  ALU and memory controls.
REQ-017 The block SHALL have ports out_wb, out_mem, out_load, out_branch, out_jump, out_imm_flag and out_illegal  out  1  control flags.

Function
REQ-018 An instruction SHALL be accepted when in_valid and in_ready are both high, and its bundle SHALL appear with out_valid=1 exactly one cycle later.
REQ-019 in_ready SHALL equal (!out_valid | out_ready) & !hazard & !flush.
REQ-020 The output registers SHALL hold their values while out_valid=1 and out_ready=0.
REQ-021 Decoding SHALL cover LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM and OP; any other opcode SHALL set out_illegal=1 and out_wb=0.
REQ-022 Immediates SHALL be sign-extended to XLEN per the RV32I I, S, B, U and J formats.
REQ-023 ALU mapping: LOAD and STORE SHALL produce funct3=000 with op2=imm; JAL and JALR SHALL produce op1=PC and op2=4; AUIPC SHALL produce op1=imm and op2=PC; LUI SHALL produce op1=imm and op2=0.
REQ-024 Register reads SHALL bypass a same-cycle write-back (wb_en, wb_rd!=0, wb_rd==rs) and return wb_value.
REQ-025 Register x0 SHALL always read as 0.
REQ-026 The load tracker SHALL be a LOAD_LAT-entry shift of rd values; an accepted LOAD SHALL enter at the head, and the tracker SHALL shift only when out_ready=1.
REQ-027 hazard SHALL be asserted when any used, nonzero source register equals a tracker entry.
REQ-028 During a hazard, no instruction SHALL be accepted, and out_valid SHALL drop to 0 once the current bundle is consumed; no NOP encoding is used.
REQ-029 On flush, at the next edge out_valid SHALL become 0 and every tracker entry SHALL be cleared; flush SHALL take priority over acceptance in the same cycle.
REQ-030 Simultaneous write-back and hazard SHALL still commit the register write.

Reset
REQ-031 While reset=0, the register file SHALL clear to 0, out_valid SHALL be 0, the tracker SHALL be cleared, and all out_* data and flags SHALL be 0.
REQ-032 Reset asserted mid-operation SHALL discard the in-flight bundle with no partial write.

Structure
REQ-033 A shared package rv_decode_pkg SHALL hold the opcode constants, the NOP encoding and the immediate-format enumeration.
REQ-034 The register file SHALL be a sub-module rv_regfile with 2 read ports, 1 write port and internal bypass, parameterised by XLEN and NREG.

Verification
REQ-035 Bench SHALL check: ADDI x5,x0,7 accepted -> next cycle out_valid=1, op1=0, op2=7, out_wb=1, out_rd=5.
REQ-036 Bench SHALL check: LW x6,0(x1) then ADD x7,x6,x2 with LOAD_LAT=1 -> in_ready=0 for exactly one out_ready cycle, then ADD issues.
REQ-037 Bench SHALL check: out_ready=0 for 3 cycles -> bundle held stable and in_ready=0.
REQ-038 Bench SHALL check: wb_en=1, wb_rd=3, wb_value=0x1234 in the same cycle as decoding ADD x4,x3,x0 -> op1=0x1234.
REQ-039 Bench SHALL check: flush asserted with an LW pending in the tracker -> out_valid=0 and a dependent instruction issues with no stall.
REQ-040 Bench SHALL check: opcode 0x7F -> out_illegal=1, out_wb=0; with NREG=16, ADD x17,... -> out_illegal=1.
